// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, operand selects
// and the decode-to-execute bundle.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] SEL_A_RS1  = 2'b00;
  localparam logic [1:0] SEL_A_PC   = 2'b01;
  localparam logic [1:0] SEL_A_ZERO = 2'b10;
  localparam logic       SEL_B_RS2  = 1'b0;
  localparam logic       SEL_B_IMM  = 1'b1;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] pc;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-side handshake and execute-side decoded bundle of the
// ALU decode stage.
interface alu_decode_stage_if;

  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  aluctrl_ctrl_o;
  logic [1:0]  alu_a_sel_o;
  logic        alu_b_sel_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;
  logic [31:0] pc_o;
  logic        illegal_o;

  modport slave (
    input  in_valid_i, instr_i, pc_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o,
    output aluctrl_ctrl_o, alu_a_sel_o,
    output alu_b_sel_o, imm_o,
    output rs1_o, rs2_o, rd_o,
    output reg_write_o, pc_o, illegal_o
  );

  modport master (
    output in_valid_i, instr_i, pc_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o,
    input  aluctrl_ctrl_o, alu_a_sel_o,
    input  alu_b_sel_o, imm_o,
    input  rs1_o, rs2_o, rd_o,
    input  reg_write_o, pc_o, illegal_o
  );

endinterface

// File: rtl/alu_decode_stage_pipe_skid.sv
// One-entry output register plus one skid slot; in_ready comes
// straight from the skid-valid flop.
module pipe_skid #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         load_out;

  assign in_ready = !skid_valid;
  assign load_out = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= RST_VAL;
      skid_data  <= RST_VAL;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      // a full skid slot means in_ready was low: input is ignored
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage feeding the ALU; registered valid/ready with skid.
// Optional illegal-instruction flagging: define ALU_DECODE_ILLEGAL_EN.
module alu_decode_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  alu_decode_stage_if.slave   bus
);

  localparam id_ex_t RST_B = '{
    ctrl:      ALU_ADD,
    a_sel:     SEL_A_RS1,
    b_sel:     SEL_B_RS2,
    imm:       '0,
    rs1:       '0,
    rs2:       '0,
    rd:        '0,
    reg_write: 1'b0,
    pc:        RESET_PC,
    illegal:   1'b0
  };

  logic [31:0]     ins;
  logic [XLEN-1:0] pc_in;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            alt;
  logic [31:0]     imm_i;
  logic [31:0]     imm_s;
  logic [31:0]     imm_b;
  logic [31:0]     imm_u;
  logic [31:0]     imm_j;
  logic [31:0]     imm_sh;
  logic            wr;
  logic            ill;
  id_ex_t          dec;
  id_ex_t          q;

  assign ins    = bus.instr_i;
  assign pc_in  = bus.pc_i;
  assign opc    = ins[6:0];
  assign f3     = ins[14:12];
  assign alt    = ins[30];

  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25],
                   ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7],
                   ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31],
                   ins[19:12], ins[20],
                   ins[30:21], 1'b0};
  assign imm_sh = {27'b0, ins[24:20]};

`ifdef ALU_DECODE_ILLEGAL_EN
  logic [6:0] f7;
  logic       f7_zero;
  logic       f7_alt;

  assign f7      = ins[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);
`endif

  always_comb begin
    dec       = '0;
    dec.ctrl  = ALU_ADD;
    dec.a_sel = SEL_A_RS1;
    dec.b_sel = SEL_B_IMM;
    dec.imm   = imm_i;
    dec.rs1   = ins[19:15];
    dec.rs2   = ins[24:20];
    dec.rd    = ins[11:7];
    dec.pc    = pc_in;
    wr        = 1'b0;
    ill       = 1'b0;
    unique case (1'b1)
      opc == OPC_OP: begin
        dec.ctrl  = {alt, f3};
        dec.b_sel = SEL_B_RS2;
        wr        = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
        ill = !(f7_zero || f7_alt) ||
              (f7[5] && f3 != 3'b000 &&
               f3 != 3'b101);
`endif
      end
      opc == OPC_OP_IMM: begin
        dec.ctrl = {(f3 == 3'b101) & alt, f3};
        wr       = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101)
          dec.imm = imm_sh;
`ifdef ALU_DECODE_ILLEGAL_EN
        ill = (f3 == 3'b001 && !f7_zero) ||
              (f3 == 3'b101 && !f7_zero &&
               !f7_alt);
`endif
      end
      opc == OPC_LUI: begin
        dec.a_sel = SEL_A_ZERO;
        dec.imm   = imm_u;
        wr        = 1'b1;
      end
      opc == OPC_AUIPC: begin
        dec.a_sel = SEL_A_PC;
        dec.imm   = imm_u;
        wr        = 1'b1;
      end
      opc == OPC_LOAD: begin
        wr = 1'b1;
      end
      opc == OPC_STORE: begin
        dec.imm = imm_s;
      end
      opc == OPC_BRANCH: begin
        dec.b_sel = SEL_B_RS2;
        dec.imm   = imm_b;
        unique case (f3[2:1])
          2'b00:   dec.ctrl = ALU_SUB;
          2'b10:   dec.ctrl = ALU_SLT;
          2'b11:   dec.ctrl = ALU_SLTU;
          default: begin
            dec.ctrl = ALU_ADD;
`ifdef ALU_DECODE_ILLEGAL_EN
            ill = 1'b1;
`endif
          end
        endcase
      end
      opc == OPC_JAL: begin
        dec.a_sel = SEL_A_PC;
        dec.imm   = imm_j;
        wr        = 1'b1;
      end
      opc == OPC_JALR: begin
        wr = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
        ill = (f3 != 3'b000);
`endif
      end
      default: begin
`ifdef ALU_DECODE_ILLEGAL_EN
        ill = 1'b1;
`endif
      end
    endcase
`ifdef ALU_DECODE_ILLEGAL_EN
    if (ill) begin
      wr       = 1'b0;
      dec.ctrl = ALU_ADD;
    end
`endif
    dec.reg_write = wr && (dec.rd != 5'd0);
    dec.illegal   = ill;
  end

  pipe_skid #(
    .W       ($bits(id_ex_t)),
    .RST_VAL (RST_B)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .in_valid  (bus.in_valid_i),
    .in_ready  (bus.in_ready_o),
    .in_data   (dec),
    .out_valid (bus.out_valid_o),
    .out_ready (bus.out_ready_i),
    .out_data  (q)
  );

  assign bus.aluctrl_ctrl_o = q.ctrl;
  assign bus.alu_a_sel_o    = q.a_sel;
  assign bus.alu_b_sel_o    = q.b_sel;
  assign bus.imm_o          = q.imm;
  assign bus.rs1_o          = q.rs1;
  assign bus.rs2_o          = q.rs2;
  assign bus.rd_o           = q.rd;
  assign bus.reg_write_o    = q.reg_write;
  assign bus.pc_o           = q.pc;
  assign bus.illegal_o      = q.illegal;

endmodule
